// File: rtl/if_id_buffer_pkg.sv
// Shared fetch/decode definitions: the canonical NOP and the IF/ID buffer depth.
package if_id_buffer_pkg;

  // addi x0, x0, 0 -- shown to decode whenever no instruction is valid.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned BUF_DEPTH = 2;

  // One buffered fetch result.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: 2-entry in-order FIFO of {instr, pc} between fetch and decode.
// Handshakes are decided from registered occupancy only, so there is no path from
// out_ready to in_ready and no same-cycle bypass from in_* to out_*.
module if_id_buffer
  import if_id_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic [1:0]  count
);

  localparam logic [1:0] CountEmpty = 2'd0;
  localparam logic [1:0] CountOne   = 2'd1;
  localparam logic [1:0] CountFull  = 2'(BUF_DEPTH);

  // head_q is the entry shown to decode; tail_q is only meaningful when full.
  fetch_entry_t head_q, head_d;
  fetch_entry_t tail_q, tail_d;
  logic [1:0]   count_q, count_d;

  fetch_entry_t in_entry;
  logic         push;
  logic         pop;

  assign in_entry = '{instr: in_instr, pc: in_pc};

  // Handshake signals come from registered occupancy only.
  always_comb begin
    in_ready  = (count_q != CountFull);
    out_valid = (count_q != CountEmpty);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Occupancy and entry update; flush wins over any push or pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      // Entries are left in place so out_pc keeps its last value.
      count_d = CountEmpty;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == CountEmpty) begin
            head_d  = in_entry;
            count_d = CountOne;
          end else begin
            tail_d  = in_entry;
            count_d = CountFull;
          end
        end
        2'b01: begin
          // Popping the last entry leaves head_q untouched so out_pc holds.
          if (count_q == CountFull) begin
            head_d = tail_q;
          end
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Only reachable with one entry: the new word replaces the head.
          head_d = in_entry;
        end
        default: begin
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '{instr: NOP_INSTR, pc: 32'h0};
      tail_q  <= '{instr: NOP_INSTR, pc: 32'h0};
      count_q <= CountEmpty;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Decode-side view of the head entry; NOP while empty, PC+4 wraps naturally.
  always_comb begin
    out_instr    = out_valid ? head_q.instr : NOP_INSTR;
    out_pc       = head_q.pc;
    out_pc_plus4 = head_q.pc + 32'd4;
    count        = count_q;
  end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: fetch presents an instruction.
REQ-004 SHALL have port in_ready, output, 1 bit: buffer can accept an instruction this cycle.
REQ-005 SHALL have port in_instr, input, 32 bits: fetched instruction word.
REQ-006 SHALL have port in_pc, input, 32 bits: PC of in_instr.
REQ-007 SHALL have port flush, input, 1 bit: discard all buffered and incoming instructions (taken branch or jump).
REQ-008 SHALL have port out_valid, output, 1 bit: decode-side instruction valid.
REQ-009 SHALL have port out_ready, input, 1 bit: decode consumes the head entry.
REQ-010 SHALL have port out_instr, output, 32 bits: head instruction to decode and immediate generation.
REQ-011 SHALL have port out_pc, output, 32 bits: PC of head entry.
REQ-012 SHALL have port out_pc_plus4, output, 32 bits: out_pc + 4, modulo 2^32.
REQ-013 SHALL have port count, output, 2 bits: occupancy, 0..2.

Function
REQ-014 SHALL be a 2-entry in-order FIFO of {instr, pc}; push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-015 in_ready SHALL equal (count != 2), derived from registered state only (no combinational path from out_ready).
REQ-016 out_valid SHALL equal (count != 0); out_instr/out_pc SHALL always show the head entry.
REQ-017 Latency SHALL be exactly 1 cycle: a push into an empty buffer appears on out_* the next cycle; no same-cycle bypass.
REQ-018 Simultaneous push and pop with count==1 SHALL leave count at 1, with the new entry at head next cycle.
REQ-019 When count==2 a push SHALL NOT occur; a pop SHALL drop count to 1 and promote the second entry.
REQ-020 When count==0 a pop SHALL NOT occur (out_valid low).
REQ-021 flush SHALL take priority: next cycle count=0, out_valid=0; any push or pop in the flush cycle is discarded.
REQ-022 While out_valid=0, out_instr SHALL read NOP (32'h00000013) and out_pc SHALL hold its last value.
REQ-023 out_pc_plus4 SHALL wrap: out_pc=32'hFFFFFFFC gives 32'h00000000.
REQ-024 out_* SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-025 When rst_n=0, SHALL immediately set count=0, out_valid=0, in_ready=1, out_instr=NOP, out_pc=0, out_pc_plus4=4.
REQ-026 Reset asserted mid-transfer SHALL discard all entries; the first push after rst_n release SHALL be accepted on the first rising edge.

Structure
REQ-027 SHALL place NOP_INSTR (32'h00000013) and BUF_DEPTH (2) in a shared package, also used by the decode stage.
REQ-028 SHALL be a single module with no sub-modules; the PC+4 adder is inline.

Verification
REQ-029 Single push, out_ready=1: in_instr=32'h00500093, pc=0x100 at cycle 0 -> out_valid=1, out_instr=32'h00500093, out_pc=0x100, out_pc_plus4=0x104 at cycle 1, then empty at cycle 2.
REQ-030 Backpressure: out_ready=0, push 3 times -> count=2, in_ready=0, third word not accepted, head unchanged; raise out_ready -> words drain in order.
REQ-031 Streaming: in_valid=out_ready=1 for 10 cycles, PCs 0x0..0x24 -> count constant at 1, one instruction per cycle, in order.
REQ-032 Flush with count=2 and a concurrent push -> next cycle count=0, out_valid=0, out_instr=32'h00000013, pushed word lost.
REQ-033 Wrap: push pc=32'hFFFFFFFC -> out_pc_plus4=32'h00000000.
REQ-034 Reset: assert rst_n=0 with count=2 between clock edges -> outputs take reset values immediately; the first push after release appears on out_* one cycle later.
